// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide sequencer owning HI/LO
//
// Purpose:
//   E-stage MDU for the pipelined MIPS core. Accepts mult/multu/div/divu,
//   computes the result at acceptance, and holds it pending for a fixed
//   latency modelled by a busy counter before committing it to HI/LO.
//   mthi/mtlo write HI/LO directly in one cycle. Raises a combinational
//   stall so the hazard unit holds MDU instructions in D.
//
// Parameters:
//   MUL_LAT  busy cycles for mult/multu (>=1)
//   DIV_LAT  busy cycles for div/divu (>=1)
//
// Ports:
//   clk      in   core clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   E-stage instruction is mult/multu/div/divu
//   mdu_op   in   1 mult, 2 div, 3 mthi, 4 mtlo, 5 multu, 6 divu, else no-op
//   flush    in   E-stage instruction cancelled this cycle
//   rs_val   in   rs operand (dividend / multiplicand / mt source)
//   rt_val   in   rt operand (divisor / multiplier)
//   ifmdu_d  in   D-stage instruction is an MDU instruction
//   busy     out  operation in flight
//   stall    out  hold D stage (combinational)
//   hi, lo   out  architectural HI/LO registers
//
// Configuration macro:
//   MDU_DIV0_KEEP_EN  defined: divide by zero leaves HI/LO unchanged.
//                     undefined: divide by zero commits LO=all ones, HI=rs.

module mdu_seq #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic        flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        ifmdu_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT);
  localparam logic [CW-1:0] CNT_DIV = CW'(DIV_LAT);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_DIVU  = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_pend_q, hi_pend_d;
  logic [31:0] lo_pend_q, lo_pend_d;
  // Set when the pending op must not touch HI/LO at commit.
  logic        keep_q, keep_d;

  // Operation decode
  logic is_mul, is_div, is_signed, accept;

  assign is_mul    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign is_div    = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  assign is_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
  assign accept    = (state_q == IDLE) && start && !flush && (is_mul || is_div);

  // Multiply: extend both operands to 64 bits so a single 64-bit product
  // covers both signed and unsigned forms.
  logic [63:0] mul_a, mul_b, prod;

  assign mul_a = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign mul_b = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign prod  = mul_a * mul_b;

  // Divide on magnitudes, then restore signs. Working on magnitudes makes
  // 0x80000000 / -1 fall out naturally as quotient 0x80000000, remainder 0.
  logic        a_neg, b_neg, div0;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign a_neg  = is_signed && rs_val[31];
  assign b_neg  = is_signed && rt_val[31];
  assign a_mag  = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign b_mag  = b_neg ? (~rt_val + 32'd1) : rt_val;
  assign div0   = (rt_val == 32'd0);
  // Keeps the divider from seeing zero; the div0 result is chosen below.
  assign b_safe = div0 ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  logic [31:0] res_hi, res_lo;
  logic        res_keep;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_keep = 1'b0;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (div0) begin
`ifdef MDU_DIV0_KEEP_EN
      res_keep = 1'b1;
`else
      res_hi = rs_val;
      res_lo = 32'hFFFF_FFFF;
`endif
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    keep_d    = keep_q;

    if (state_q == IDLE) begin
      if (accept) begin
        hi_pend_d = res_hi;
        lo_pend_d = res_lo;
        keep_d    = res_keep;
        cnt_d     = is_mul ? CNT_MUL : CNT_DIV;
        state_d   = RUN;
      end else if (!flush && (mdu_op == OP_MTHI)) begin
        hi_d = rs_val;
      end else if (!flush && (mdu_op == OP_MTLO)) begin
        lo_d = rs_val;
      end
    end else begin
      // RUN ignores every command and flush; the op is already past E.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        if (!keep_q) begin
          hi_d = hi_pend_q;
          lo_d = lo_pend_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      keep_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      keep_q    <= keep_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = ifmdu_d && (busy || accept);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq

module tb_mdu_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  mdu_op;
  logic        flush;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ifmdu_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_seq #(
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .flush   (flush),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .ifmdu_d (ifmdu_d),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        unch;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic st, input logic [3:0] op,
                     input logic [31:0] rs, input logic [31:0] rt, input logic unch,
                     input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    vec_t v;
    v.name = n; v.st = st; v.op = op; v.rs = rs; v.rt = rt;
    v.unch = unch; v.ehi = ehi; v.elo = elo; v.lat = lat;
    vq.push_back(v);
  endtask

  // Issue one command in a single cycle, then count busy cycles (bounded).
  task automatic run_op(input logic st, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, output int nbusy);
    @(negedge clk);
    start = st; mdu_op = op; rs_val = rs; rt_val = rt;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    nbusy = 0;
    while (busy && nbusy < 60) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  logic [31:0] cur_hi, cur_lo;
  int          nb;

  initial begin
    reset_n = 1'b0; start = 1'b0; mdu_op = 4'd0; flush = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0; ifmdu_d = 1'b0;

    // Vector table: name, start, op, rs, rt, unchanged, hi, lo, latency
    add("multu_ff_2",   1, 4'd5, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    add("div_m7_2",     1, 4'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    add("mthi",         0, 4'd3, 32'h1234_5678, 32'h0,         0, 32'h1234_5678, 32'hFFFF_FFFD, 0);
    add("mtlo",         0, 4'd4, 32'h9ABC_DEF0, 32'h0,         0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    add("mult_m1_3",    1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0003, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5);
    add("mult_min_min", 1, 4'd1, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'h0000_0000, 5);
    add("multu_ff_ff",  1, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    add("mult_m1_m1",   1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h0000_0001, 5);
    add("div_ovf",      1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 10);
    add("divu_100_7",   1, 4'd6, 32'h0000_0064, 32'h0000_0007, 0, 32'h0000_0002, 32'h0000_000E, 10);
    add("div_7_m2",     1, 4'd2, 32'h0000_0007, 32'hFFFF_FFFE, 0, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    add("div_negodd_7", 1, 4'd2, 32'h8000_0001, 32'h0000_0007, 0, 32'hFFFF_FFFF, 32'hEDB6_DB6E, 10);
    add("divu_big_2",   1, 4'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'h0000_0001, 32'h7FFF_FFFC, 10);
`ifdef MDU_DIV0_KEEP_EN
    add("divu_by0",     1, 4'd6, 32'h0000_0055, 32'h0,         1, 32'h0,         32'h0,         10);
    add("div_by0",      1, 4'd2, 32'hFFFF_FF00, 32'h0,         1, 32'h0,         32'h0,         10);
`else
    add("divu_by0",     1, 4'd6, 32'h0000_0055, 32'h0,         0, 32'h0000_0055, 32'hFFFF_FFFF, 10);
    add("div_by0",      1, 4'd2, 32'hFFFF_FF00, 32'h0,         0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 10);
`endif
    add("noop_op0",     1, 4'd0, 32'h1111_1111, 32'h2222_2222, 1, 32'h0,         32'h0,         0);
    add("noop_op7",     1, 4'd7, 32'h3333_3333, 32'h4444_4444, 1, 32'h0,         32'h0,         0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    cur_hi = 32'd0; cur_lo = 32'd0;

    // Table-driven vectors
    foreach (vq[i]) begin
      run_op(vq[i].st, vq[i].op, vq[i].rs, vq[i].rt, nb);
      if (!vq[i].unch) begin
        cur_hi = vq[i].ehi;
        cur_lo = vq[i].elo;
      end
      chk({vq[i].name, "_busy"}, 32'(nb), 32'(vq[i].lat));
      chk({vq[i].name, "_hi"}, hi, cur_hi);
      chk({vq[i].name, "_lo"}, lo, cur_lo);
    end

    // div with ifmdu_d held: stall from start cycle through T+10
    ifmdu_d = 1'b1;
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd2; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
    #1 chk("stall_T", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("stall_T+%0d", c), {30'd0, stall, busy}, 32'd3);
      @(negedge clk);
    end
    chk("stall_T+11", {30'd0, stall, busy}, 32'd0);
    chk("stall_div_hi", hi, 32'hFFFF_FFFF);
    chk("stall_div_lo", lo, 32'hFFFF_FFFD);

    // Back-to-back mthi / mtlo, no stall and no busy
    start = 1'b0; mdu_op = 4'd3; rs_val = 32'h1234_5678;
    #1 chk("mthi_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    mdu_op = 4'd4; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    mdu_op = 4'd0; rs_val = 32'd0;

    // Flushed start is not accepted
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3; flush = 1'b1;
    #1 chk("flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h9ABC_DEF0);

    // mult whose RUN sees a flush and a stray mthi; result still commits
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
    #1 chk("mult_acc_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    nb = 0;
    while (busy && nb < 60) begin
      nb++;
      if (nb == 2) begin
        flush = 1'b1; start = 1'b1; mdu_op = 4'd3; rs_val = 32'hDEAD_BEEF;
      end else begin
        flush = 1'b0; start = 1'b0; mdu_op = 4'd0;
      end
      @(negedge clk);
    end
    chk("run_flush_busy", 32'(nb), 32'd5);
    chk("run_flush_hi", hi, 32'd0);
    chk("run_flush_lo", lo, 32'd6);

    // Back-to-back start in the first idle cycle
    start = 1'b1; mdu_op = 4'd5; rs_val = 32'd4; rt_val = 32'd5;
    #1 chk("b2b_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    nb = 0;
    while (busy && nb < 60) begin
      nb++;
      @(negedge clk);
    end
    chk("b2b_busy", 32'(nb), 32'd5);
    chk("b2b_lo", lo, 32'd20);
    ifmdu_d = 1'b0;

    // Asynchronous reset in the third busy cycle of a div
    run_op(1'b0, 4'd3, 32'hAAAA_5555, 32'd0, nb);
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits in the E stage and accepts mult/multu/div/divu/mthi/mtlo commands from the decoded E-stage instruction. It owns the architectural HI/LO registers and models the fixed multiply and divide latencies with a busy counter. It also raises the stall request that the hazard unit uses to hold MDU instructions in D while an operation is in flight.

## Interface
Parameters:
- `MUL_LAT`, default 5: busy cycles for mult/multu; must be ≥1.
- `DIV_LAT`, default 10: busy cycles for div/divu; must be ≥1.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  E-stage instruction is mult/multu/div/divu.
- `mdu_op`  in  4  operation code: 1 mult, 2 div, 3 mthi, 4 mtlo, 5 multu, 6 divu; 0 and 7–15 are no-op.
- `flush`  in  1  E-stage instruction is being cancelled by an exception or interrupt this cycle; suppresses acceptance.
- `rs_val`  in  32  forwarded rs operand (dividend / multiplicand / mt source).
- `rt_val`  in  32  forwarded rt operand (divisor / multiplier).
- `ifmdu_d`  in  1  D-stage instruction is any MDU instruction (mult, multu, div, divu, mthi, mtlo, mfhi, mflo).
- `busy`  out  1  an operation is in flight.
- `stall`  out  1  hold the D stage; combinational.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE and RUN.
- Registers:
  - `cnt`, a counter.
  - `hi_pend` and `lo_pend`, the pending result.
- Accept condition: state IDLE, `start`=1, `flush`=0, and `mdu_op` in {1,2,5,6}.
- On accept:
  - Compute the result from `rs_val` and `rt_val` and latch it into `hi_pend`/`lo_pend`.
  - Load `cnt` with `MUL_LAT` for mult/multu, or `DIV_LAT` for div/divu.
  - Go to RUN.
- RUN:
  - Decrement `cnt` each cycle.
  - In the cycle with `cnt`==1: commit `hi_pend`/`lo_pend` to `hi`/`lo` at the clock edge and return to IDLE.
- mult/multu: the 64-bit product, signed or unsigned; `hi`=[63:32], `lo`=[31:0].
- div/divu: `lo`=quotient, `hi`=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Special case: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Divide by zero: see Configuration.
- mthi/mtlo: in IDLE with `flush`=0, write `rs_val` into `hi`/`lo` at the edge. Single cycle; never asserts busy.
- `busy` = (state==RUN).
- `stall` = `ifmdu_d` & (`busy` | accepted `start` this cycle).
- Commands arriving while in RUN are ignored. The hazard unit prevents this via `stall`, and the bench checks it as protocol.
- `flush` never cancels an operation already in RUN; that instruction has already been committed past E.
- Reset mid-operation: return to IDLE, discard the pending result, and clear `hi`/`lo`.

## Timing
- Reset values:
  - `hi`=0, `lo`=0.
  - `busy`=0, `stall`=0 (with `ifmdu_d`=0).
  - `cnt`=0, state IDLE.
- For a start accepted in cycle T with latency L:
  - `busy`=1 in cycles T+1..T+L.
  - The new `hi`/`lo` is visible from cycle T+L+1, the first cycle with `busy`=0.
- A back-to-back start in cycle T+L+1 is accepted; no dead cycle.
- mthi/mtlo in cycle T: the value is visible on `hi`/`lo` in T+1.
- `stall` is combinational from `ifmdu_d`, `start` and state. There is no combinational path from `rs_val`/`rt_val` to any output.
- `flush` and `start` in the same cycle: nothing is accepted, the state is unchanged, and `stall` follows `busy` only.

## Configuration
- `MDU_DIV0_KEEP_EN` defined: div/divu with `rt_val`=0 still runs the full `DIV_LAT` busy period, but `hi`/`lo` are left unchanged at commit.
- `MDU_DIV0_KEEP_EN` undefined: on divide by zero, commit `lo`=0xFFFFFFFF and `hi`=`rs_val`, for both signed and unsigned division.

## Test plan
- Reset, then multu with rs=0xFFFFFFFF, rt=0x00000002 → `busy`=1 for exactly 5 cycles, then `hi`=0x00000001, `lo`=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (-7), rt=2 → `busy` for 10 cycles, then `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1); with `ifmdu_d`=1 throughout, `stall`=1 from the start cycle through T+10 and 0 at T+11.
- mthi with rs=0x12345678, then mtlo with rs=0x9ABCDEF0 in the next cycle → `hi`/`lo` update one cycle after each command, and `busy` stays 0.
- mult with `flush`=1 in the same cycle → not accepted, `busy` stays 0, `hi`/`lo` unchanged. Then raise `flush` during the RUN of a subsequent mult → the result still commits.
- divu with rt=0 and rs=0x55 → with `MDU_DIV0_KEEP_EN`, `hi`/`lo` are unchanged after 10 cycles; without it, `lo`=0xFFFFFFFF and `hi`=0x55.
- Deassert `reset_n` asynchronously in the third busy cycle of a div → `busy`, `hi` and `lo` are 0 immediately; after release the operation never commits.
